mem_io_responder: RTL

Memory-side responder for the CPU controller's fetch, load and store requests. It services single-word reads and writes to on-chip RAM and to three memory-mapped I/O registers: switch input, LED output and a free-running cycle counter. Each accepted request gets a one-cycle acknowledge, so the controller's wait states can be replaced by a real handshake. It sits between the controller/datapath address and data buses and the board I/O.

---
 rtl/mem_io_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: single-word RAM and memory-mapped I/O responder
// giving the CPU controller a one-cycle acknowledge per request.
module mem_io_responder #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] maddr,
    input  logic          mread,
    input  logic          mwrite,
    input  logic [DW-1:0] mdin,
    output logic [DW-1:0] mdout,
    output logic          mack,
    output logic          ready,
    input  logic [7:0]    sw,
    output logic [7:0]    ledr
);

    localparam logic [AW-1:0] A_SW  = '1;
    localparam logic [AW-1:0] A_LED = A_SW - AW'(1);
    localparam logic [AW-1:0] A_CNT = A_SW - AW'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RWAIT,
        S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      lat_q, lat_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            rram_q, rram_d;
    logic [DW-1:0]   rval_q, rval_d;
    logic [DW-1:0]   mdout_q, mdout_d;
    logic [7:0]      ledr_q, ledr_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sw1_q, sw1_d;
    logic [7:0]      sw2_q, sw2_d;
    logic [DW-1:0]   mem_q [2**AW];
    logic            mem_we;
    logic            addr_is_ram;
    logic [DW-1:0]   live_val;

    assign mdout = mdout_q;
    assign ledr  = ledr_q;

    // Decode the request address and fetch the value it would return now
    always_comb begin
        addr_is_ram = (maddr < A_CNT);
        live_val    = mem_q[maddr];
        if (maddr == A_SW) begin
            live_val = DW'(sw2_q);
        end else if (maddr == A_LED) begin
            live_val = DW'(ledr_q);
        end else if (maddr == A_CNT) begin
            live_val = cnt_q;
        end
    end

    // Handshake FSM next state, I/O register updates and read data capture
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        raddr_d = raddr_q;
        rram_d  = rram_q;
        rval_d  = rval_q;
        mdout_d = mdout_q;
        ledr_d  = ledr_q;
        cnt_d   = cnt_q + DW'(1);
        sw1_d   = sw;
        sw2_d   = sw1_q;
        mem_we  = 1'b0;
        ready   = 1'b0;
        mack    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (mwrite) begin
                    state_d = S_ACK;
                    if (addr_is_ram) begin
                        mem_we = 1'b1;
                    end else if (maddr == A_LED) begin
                        ledr_d = mdin[7:0];
                    end else if (maddr == A_CNT) begin
                        cnt_d = '0;
                    end
                end else if (mread) begin
                    raddr_d = maddr;
                    rram_d  = addr_is_ram;
                    rval_d  = live_val;
                    lat_d   = 3'(RD_LAT - 1);
                    if (RD_LAT == 1) begin
                        state_d = S_ACK;
                        mdout_d = live_val;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_RWAIT: begin
                if (lat_q == 3'd0) begin
                    state_d = S_ACK;
                    mdout_d = rram_q ? mem_q[raddr_q] : rval_q;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_ACK: begin
                mack    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and I/O registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            raddr_q <= '0;
            rram_q  <= 1'b0;
            rval_q  <= '0;
            mdout_q <= '0;
            ledr_q  <= '0;
            cnt_q   <= '0;
            sw1_q   <= '0;
            sw2_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            raddr_q <= raddr_d;
            rram_q  <= rram_d;
            rval_q  <= rval_d;
            mdout_q <= mdout_d;
            ledr_q  <= ledr_d;
            cnt_q   <= cnt_d;
            sw1_q   <= sw1_d;
            sw2_q   <= sw2_d;
        end
    end

    // RAM array keeps its contents across reset
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[maddr] <= mdin;
        end
    end

endmodule
